uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Parametrised UART transmitter that replaces the split FSM, shift register and mux arrangement with a single self-timed block. It includes its own baud-tick generator. Frame format is configurable: data width by parameter; parity mode and stop-bit count at run time, latched per frame. It sits between the host-side byte source (valid/ready handshake) and the tx pad.

Parameters:
DATA_BITS, 8, payload width in bits; legal range 5..9.
BAUD_DIV, 16, Clk cycles per serial bit; legal range 2..65535.
CNT_W, $clog2(BAUD_DIV), baud counter width; derived, not overridden.

Ports:
Clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
tx_data_in  input  DATA_BITS  payload; sampled on acceptance.
tx_valid_in  input  1  payload valid.
tx_ready_out  output  1  block can accept a frame.
parity_mode_in  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none); sampled on acceptance.
two_stop_in  input  1  0 = one stop bit, 1 = two stop bits; sampled on acceptance.
tx_serial_out  output  1  serial line, registered, idle high.
tx_busy_out  output  1  high while a frame is in progress.
tx_done_out  output  1  one-cycle pulse at the end of the frame.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state = IDLE; tx_serial_out = 1; tx_ready_out = 1; tx_busy_out = 0; tx_done_out = 0.
  - Baud counter, bit counter, shift register and latched config are all cleared.
  - A partially sent frame is abandoned; there is no resume.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is 3 bits, defined in the package.
- tx_ready_out = (state == IDLE).
- Acceptance: on a rising edge with tx_valid_in & tx_ready_out, the block:
  - latches tx_data_in, parity_mode_in and two_stop_in;
  - computes parity from the latched data;
  - enters START.
- Latency: tx_serial_out goes 0 on the clock edge that accepts the frame, so it is low in the first cycle after acceptance.
- tx_valid_in while not ready is ignored. Inputs changing mid-frame have no effect.
- Bit timing: every serial bit is held exactly BAUD_DIV cycles.
  - The baud counter runs 0..BAUD_DIV-1 and is reset to 0 on acceptance.
  - Bit end = counter at BAUD_DIV-1. All state transitions occur only at bit end.
- Transitions (at bit end):
  - START -> DATA.
  - DATA: shift LSB first. After DATA_BITS bits, go to PARITY if the latched mode is 01/10, else go to STOP.
  - PARITY: even = XOR of data bits; odd = inverted XOR. Then go to STOP.
  - STOP: line = 1. With two stop bits, stay for a second bit period (stop counter). Then go to IDLE.
- Frame length = (1 + DATA_BITS + P + S) * BAUD_DIV cycles, where P = 0/1 and S = 1/2.
- tx_busy_out: 1 from the cycle after acceptance through the last cycle of the final stop bit.
- tx_done_out: asserted for exactly one cycle, in the first IDLE cycle after the frame.
- Back-to-back frames:
  - A frame can be accepted in the same cycle that tx_done_out is high.
  - The stop period is therefore extended by exactly 1 Clk cycle; there are no other idle gaps.
- Counter widths:
  - The bit counter holds 0..DATA_BITS-1 and wraps only through state exit.
  - The baud counter never exceeds BAUD_DIV-1.

Decomposition:
- Package uart_pkg holds:
  - tx state encoding: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - parity mode constants: PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD;
  - the default BAUD_DIV.
- Sub-module uart_baud_gen (parameter BAUD_DIV):
  - inputs: Clk, reset, clear, enable;
  - output: bit_end pulse.
  - It is reused by the future receiver.

Test Plan:
1. DATA_BITS=8, BAUD_DIV=4, data 0xA5, even parity, one stop -> line bits 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles. Then 44 busy cycles, then a single tx_done_out pulse.
2. Same data with odd parity and two stop bits -> parity bit 1, stop high for 8 cycles, 48-cycle frame. Separately, parity_mode=11 -> no parity bit, 40-cycle frame.
3. DATA_BITS=7, data 0x41, no parity -> bits 0,1,0,0,0,0,0,1,1 (start, 7 data bits, stop). Check the 36-cycle frame.
4. tx_valid_in held high with 0x55 then 0x0F queued -> second start bit begins the cycle after tx_done_out. The first frame's stop is 5 cycles; no extra idle. Valid pulses during busy are ignored.
5. Assert reset in the middle of the data bits -> tx_serial_out = 1 and tx_ready_out = 1 immediately (async), busy/done = 0. The next accepted frame is fully correct.
6. Change parity_mode_in, two_stop_in and tx_data_in mid-frame -> the transmitted frame matches the values latched at acceptance.

Source files
------------

// File: rtl/uart_tx_engine_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and
// small frame-format helpers used by the tx engine and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_e;

    localparam int DEFAULT_BAUD_DIV = 16;

    // Reserved mode sends no parity bit, same as PAR_NONE.
    function automatic logic parity_on(input parity_mode_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic parity_bit(input logic data_xor, input parity_mode_e mode);
        return data_xor ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Host-side byte handshake plus serial/status outputs of the UART transmitter.
interface uart_tx_engine_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data_in;
    logic                 tx_valid_in;
    logic                 tx_ready_out;
    logic [1:0]           parity_mode_in;
    logic                 two_stop_in;
    logic                 tx_serial_out;
    logic                 tx_busy_out;
    logic                 tx_done_out;

    modport master (
        output tx_data_in, tx_valid_in, parity_mode_in, two_stop_in,
        input  tx_ready_out, tx_serial_out, tx_busy_out, tx_done_out
    );

    modport slave (
        input  tx_data_in, tx_valid_in, parity_mode_in, two_stop_in,
        output tx_ready_out, tx_serial_out, tx_busy_out, tx_done_out
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter; bit_end marks the last Clk cycle of each
// serial bit. Shared between transmitter and receiver.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int CNT_W    = $clog2(BAUD_DIV)
) (
    input  logic Clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end

    assign bit_end = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: accepts a payload on valid/ready, latches the frame format
// and shifts start/data/parity/stop bits out LSB first on a registered line.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter  int DATA_BITS = 8,
    parameter  int BAUD_DIV  = DEFAULT_BAUD_DIV,
    localparam int CNT_W     = $clog2(BAUD_DIV)
) (
    input  logic           Clk,
    input  logic           reset,
    uart_tx_engine_if.slave bus
);
    localparam int             BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 par_en_q, par_bit_q, two_stop_q;
    logic                 serial_q, done_q;
    logic                 serial_d, done_d;
    logic                 bit_end, accept, last_bit, last_stop;
    parity_mode_e         mode_in;

    assign mode_in   = parity_mode_e'(bus.parity_mode_in);
    assign accept    = bus.tx_valid_in && (state_q == IDLE);
    assign last_bit  = (bit_cnt_q == LAST_BIT);
    assign last_stop = !two_stop_q || stop_cnt_q;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV),
        .CNT_W    (CNT_W)
    ) u_baud (
        .Clk     (Clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (state_q != IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)              state_d = START;
            START:   if (bit_end)             state_d = DATA;
            DATA:    if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end)             state_d = STOP;
            STOP:    if (bit_end && last_stop) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // The line is registered, so it is driven from the state being entered;
    // within DATA the next bit is shreg[1] only on the edge that shifts.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = (state_q == DATA && bit_end) ? shreg_q[1] : shreg_q[0];
            PARITY:  serial_d = par_bit_q;
            default: serial_d = 1'b1;
        endcase
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (accept) begin
            shreg_q    <= bus.tx_data_in;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= parity_on(mode_in);
            par_bit_q  <= parity_bit(^bus.tx_data_in, mode_in);
            two_stop_q <= bus.two_stop_in;
        end else if (bit_end) begin
            if (state_q == DATA) begin
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BIT_W'(1);
                if (!last_bit)
                    shreg_q <= shreg_q >> 1;
            end
            if (state_q == STOP)
                stop_cnt_q <= !last_stop;
        end
    end

    assign bus.tx_serial_out = serial_q;
    assign bus.tx_done_out   = done_q;
    assign bus.tx_ready_out  = (state_q == IDLE);
    assign bus.tx_busy_out   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frames are predicted as a list of line bits from
// the frame format and compared cycle by cycle against the serial output.
module tb_uart_tx_engine;
    import uart_pkg::*;

    localparam int B = 4;

    logic Clk   = 1'b0;
    logic reset = 1'b1;
    always #5 Clk = ~Clk;

    uart_tx_engine_if #(.DATA_BITS(8)) bus8();
    uart_tx_engine_if #(.DATA_BITS(7)) bus7();

    uart_tx_engine #(.DATA_BITS(8), .BAUD_DIV(B)) dut8 (.Clk(Clk), .reset(reset), .bus(bus8));
    uart_tx_engine #(.DATA_BITS(7), .BAUD_DIV(B)) dut7 (.Clk(Clk), .reset(reset), .bus(bus7));

    int checks = 0;
    int errors = 0;
    bit exp_bits[16];
    int exp_n;

    // Reference frame: start, data LSB first, optional parity, stop bit(s).
    task automatic build_bits(input logic [8:0] d, input int nbits, input logic [1:0] m, input logic two);
        int ones;
        ones = 0;
        exp_bits[0] = 1'b0;
        exp_n = 1;
        for (int i = 0; i < nbits; i++) begin
            exp_bits[exp_n] = d[i];
            exp_n++;
            ones += int'(d[i]);
        end
        if (m == 2'b01 || m == 2'b10) begin
            exp_bits[exp_n] = ((ones % 2) == 1) ^ (m == 2'b10);
            exp_n++;
        end
        exp_bits[exp_n] = 1'b1;
        exp_n++;
        if (two) begin
            exp_bits[exp_n] = 1'b1;
            exp_n++;
        end
    endtask

    task automatic present(input logic [7:0] d, input logic [1:0] m, input logic t);
        bus8.tx_data_in     = d;
        bus8.parity_mode_in = m;
        bus8.two_stop_in    = t;
        bus8.tx_valid_in    = 1'b1;
    endtask

    // after: 0 = valid low during frame, 1 = random input churn during frame,
    //        2 = next frame (nd/nm/nt) held valid for back-to-back acceptance.
    task automatic check_frame(input logic [7:0] d, input logic [1:0] m, input logic t, input int after,
                               input logic [7:0] nd, input logic [1:0] nm, input logic nt, input string tag);
        int bad_cyc, busy_n, len;
        logic bad_val;
        bad_cyc = -1;
        bad_val = 1'b0;
        busy_n  = 0;
        build_bits({1'b0, d}, 8, m, t);
        len = exp_n * B;
        checks++;
        if (bus8.tx_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b want 1", tag, bus8.tx_ready_out);
        end
        @(posedge Clk);
        @(negedge Clk);
        if (after == 2) begin
            bus8.tx_data_in     = nd;
            bus8.parity_mode_in = nm;
            bus8.two_stop_in    = nt;
        end else begin
            bus8.tx_valid_in = 1'b0;
        end
        for (int c = 0; c < len; c++) begin
            if (bad_cyc < 0 && bus8.tx_serial_out !== exp_bits[c / B]) begin
                bad_cyc = c;
                bad_val = bus8.tx_serial_out;
            end
            if (bus8.tx_busy_out === 1'b1 && bus8.tx_done_out === 1'b0 && bus8.tx_ready_out === 1'b0)
                busy_n++;
            if (after == 1) begin
                bus8.tx_data_in     = 8'($urandom);
                bus8.parity_mode_in = 2'($urandom);
                bus8.two_stop_in    = 1'($urandom);
                bus8.tx_valid_in    = 1'($urandom);
            end
            @(negedge Clk);
        end
        checks++;
        if (bad_cyc >= 0) begin
            errors++;
            $display("FAIL %s line at cycle %0d got %b want %b", tag, bad_cyc, bad_val, exp_bits[bad_cyc / B]);
        end
        checks++;
        if (busy_n !== len) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_n, len);
        end
        checks++;
        if ({bus8.tx_done_out, bus8.tx_busy_out, bus8.tx_ready_out, bus8.tx_serial_out} !== 4'b1011) begin
            errors++;
            $display("FAIL %s end_of_frame done/busy/ready/line got %b%b%b%b want 1011", tag,
                     bus8.tx_done_out, bus8.tx_busy_out, bus8.tx_ready_out, bus8.tx_serial_out);
        end
        if (after != 2) begin
            bus8.tx_valid_in = 1'b0;
            @(negedge Clk);
            checks++;
            if (bus8.tx_done_out !== 1'b0 || bus8.tx_ready_out !== 1'b1) begin
                errors++;
                $display("FAIL %s done_single_pulse done=%b ready=%b want 0 1", tag,
                         bus8.tx_done_out, bus8.tx_ready_out);
            end
        end
    endtask

    task automatic test_reset();
        bus8.tx_valid_in = 1'b0; bus8.tx_data_in = '0; bus8.parity_mode_in = '0; bus8.two_stop_in = 1'b0;
        bus7.tx_valid_in = 1'b0; bus7.tx_data_in = '0; bus7.parity_mode_in = '0; bus7.two_stop_in = 1'b0;
        reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({bus8.tx_serial_out, bus8.tx_ready_out, bus8.tx_busy_out, bus8.tx_done_out} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_state8 line/ready/busy/done got %b%b%b%b want 1100",
                     bus8.tx_serial_out, bus8.tx_ready_out, bus8.tx_busy_out, bus8.tx_done_out);
        end
        checks++;
        if ({bus7.tx_serial_out, bus7.tx_ready_out, bus7.tx_busy_out, bus7.tx_done_out} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_state7 line/ready/busy/done got %b%b%b%b want 1100",
                     bus7.tx_serial_out, bus7.tx_ready_out, bus7.tx_busy_out, bus7.tx_done_out);
        end
        reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_even_parity();
        present(8'hA5, 2'b01, 1'b0);
        check_frame(8'hA5, 2'b01, 1'b0, 0, 8'h00, 2'b00, 1'b0, "even_a5");
    endtask

    task automatic test_odd_two_stop();
        present(8'hA5, 2'b10, 1'b1);
        check_frame(8'hA5, 2'b10, 1'b1, 0, 8'h00, 2'b00, 1'b0, "odd_two_stop");
        present(8'hA5, 2'b11, 1'b0);
        check_frame(8'hA5, 2'b11, 1'b0, 0, 8'h00, 2'b00, 1'b0, "reserved_mode");
    endtask

    task automatic test_data7();
        int bad_cyc, busy_n, len;
        bad_cyc = -1;
        busy_n  = 0;
        build_bits(9'h041, 7, 2'b00, 1'b0);
        len = exp_n * B;
        bus7.tx_data_in = 7'h41; bus7.parity_mode_in = 2'b00; bus7.two_stop_in = 1'b0; bus7.tx_valid_in = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus7.tx_valid_in = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (bad_cyc < 0 && bus7.tx_serial_out !== exp_bits[c / B]) bad_cyc = c;
            if (bus7.tx_busy_out === 1'b1) busy_n++;
            @(negedge Clk);
        end
        checks++;
        if (bad_cyc >= 0) begin
            errors++;
            $display("FAIL data7 line at cycle %0d want %b", bad_cyc, exp_bits[bad_cyc / B]);
        end
        checks++;
        if (busy_n !== len || bus7.tx_busy_out !== 1'b0) begin
            errors++;
            $display("FAIL data7 frame_length got %0d busy_after=%b want %0d busy_after=0", busy_n, bus7.tx_busy_out, len);
        end
        checks++;
        if (bus7.tx_done_out !== 1'b1) begin
            errors++;
            $display("FAIL data7 done got %b want 1", bus7.tx_done_out);
        end
        @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        present(8'h55, 2'b01, 1'b0);
        check_frame(8'h55, 2'b01, 1'b0, 2, 8'h0F, 2'b10, 1'b1, "b2b_first");
        check_frame(8'h0F, 2'b10, 1'b1, 0, 8'h00, 2'b00, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        present(8'hC3, 2'b01, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        bus8.tx_valid_in = 1'b0;
        repeat (B * 3 + 1) @(negedge Clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus8.tx_serial_out, bus8.tx_ready_out, bus8.tx_busy_out, bus8.tx_done_out} !== 4'b1100) begin
            errors++;
            $display("FAIL async_reset_mid_frame line/ready/busy/done got %b%b%b%b want 1100",
                     bus8.tx_serial_out, bus8.tx_ready_out, bus8.tx_busy_out, bus8.tx_done_out);
        end
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        d = 8'($urandom);
        present(d, 2'b10, 1'b0);
        check_frame(d, 2'b10, 1'b0, 0, 8'h00, 2'b00, 1'b0, "after_reset");
    endtask

    task automatic test_mid_frame_changes();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] d;
            logic [1:0] m;
            logic       t;
            d = 8'($urandom); m = 2'($urandom); t = 1'($urandom);
            present(d, m, t);
            check_frame(d, m, t, 1, 8'h00, 2'b00, 1'b0, "mid_frame_churn");
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] d;
            logic [1:0] m;
            logic       t;
            d = 8'($urandom); m = 2'($urandom_range(0, 3)); t = 1'($urandom);
            present(d, m, t);
            check_frame(d, m, t, int'($urandom_range(0, 1)), 8'h00, 2'b00, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_two_stop();
        test_data7();
        test_back_to_back();
        test_reset_mid_frame();
        test_mid_frame_changes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
